// File: rtl/csr_pkg.sv
// Shared types and default widths for the CSR encoder datapath.
package csr_pkg;
    localparam int CSR_DATA_W   = 14;
    localparam int CSR_IDX_W    = 14;
    localparam int CSR_CNT_W    = 28;
    localparam int CSR_RP_START = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RP0,
        ST_SCAN,
        ST_RP,
        ST_FLUSH,
        ST_DONE
    } csr_state_e;
endpackage

// File: rtl/csr_enc_out_slot.sv
// One-entry valid/ready output register; a load in the same cycle as a drain
// replaces the entry without a bubble.
module csr_enc_out_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/csr_enc_core.sv
// Streaming dense-to-CSR encoder: emits (value, column) nonzeros and rows+1
// row pointers for a row-major input matrix.
module csr_enc_core
    import csr_pkg::*;
#(
    parameter int DATA_W = CSR_DATA_W,
    parameter int IDX_W  = CSR_IDX_W,
    parameter int CNT_W  = CSR_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  cfg_rows,
    input  logic [IDX_W-1:0]  cfg_cols,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] nz_val,
    output logic [IDX_W-1:0]  nz_col,
    output logic              nz_valid,
    input  logic              nz_ready,
    output logic [CNT_W-1:0]  rp_data,
    output logic              rp_valid,
    input  logic              rp_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    csr_state_e state, state_next;

    logic [IDX_W-1:0]        rows_q, cols_q, row, col;
    logic [CNT_W-1:0]        nnz;
    logic                    start_ok, accept, last_col, last_row, rp_take;
    logic                    nz_load, rp_load;
    logic [CNT_W-1:0]        rp_load_data;
    logic [DATA_W+IDX_W-1:0] nz_slot_data;

    assign start_ok = start && (cfg_rows != '0) && (cfg_cols != '0);
    assign in_ready = (state == ST_SCAN) && (!nz_valid || nz_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (col == cols_q - IDX_W'(1));
    assign last_row = (row == rows_q - IDX_W'(1));
    assign rp_take  = rp_valid && rp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_ok) state_next = ST_RP0;
            ST_RP0:   if (rp_take) state_next = ST_SCAN;
            ST_SCAN:  if (accept && last_col) state_next = ST_RP;
            ST_RP:    if (rp_take) state_next = last_row ? ST_FLUSH : ST_SCAN;
            ST_FLUSH: if (!nz_valid) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Row pointers are loaded on entry to RP0/RP, so the count already includes
    // a nonzero arriving as the row's last element.
    always_comb begin
        nz_load      = 1'b0;
        rp_load      = 1'b0;
        rp_load_data = '0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    rp_load      = 1'b1;
                    rp_load_data = CNT_W'(CSR_RP_START);
                end
            end
            ST_SCAN: begin
                nz_load = accept && (in_data != '0);
                if (accept && last_col) begin
                    rp_load      = 1'b1;
                    rp_load_data = nnz + CNT_W'(nz_load);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q  <= '0;
            cols_q  <= '0;
            row     <= '0;
            col     <= '0;
            nnz     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            busy    <= (state_next != ST_IDLE);
            done    <= (state == ST_DONE);
            cfg_err <= (state == ST_IDLE) && start && !start_ok;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        rows_q <= cfg_rows;
                        cols_q <= cfg_cols;
                    end
                end
                ST_RP0: begin
                    if (rp_take) begin
                        row <= '0;
                        col <= '0;
                        nnz <= '0;
                    end
                end
                ST_SCAN: begin
                    if (accept) begin
                        col <= last_col ? '0 : col + IDX_W'(1);
                        if (nz_load) nnz <= nnz + CNT_W'(1);
                    end
                end
                ST_RP: begin
                    if (rp_take) row <= row + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    csr_enc_out_slot #(.W(DATA_W + IDX_W)) u_nz_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (nz_load),
        .load_data ({in_data, col}),
        .valid     (nz_valid),
        .ready     (nz_ready),
        .data      (nz_slot_data)
    );

    assign nz_val = nz_slot_data[DATA_W+IDX_W-1:IDX_W];
    assign nz_col = nz_slot_data[IDX_W-1:0];

    csr_enc_out_slot #(.W(CNT_W)) u_rp_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (rp_load),
        .load_data (rp_load_data),
        .valid     (rp_valid),
        .ready     (rp_ready),
        .data      (rp_data)
    );

endmodule

// File: tb/tb_csr_enc_core.sv
// Directed self-checking bench for csr_enc_core.
module tb_csr_enc_core;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready;
    logic [13:0] cfg_rows, cfg_cols, in_data, nz_val, nz_col;
    logic        nz_valid, nz_ready, rp_valid, rp_ready, busy, done, cfg_err;
    logic [27:0] rp_data;

    logic nzReadyMain = 1'b1;
    logic toggleMode  = 1'b0;
    logic toggleBit   = 1'b0;
    assign nz_ready = toggleMode ? toggleBit : nzReadyMain;

    int passCount = 0;
    int totalCount = 0;

    logic [13:0] nzValQ[$];
    logic [13:0] nzColQ[$];
    logic [27:0] rpQ[$];
    int doneCount = 0, errCount = 0, violations = 0, blocked = 0;
    logic busyAtDone = 1'b1, busyBeforeDone = 1'b0, lastBusy = 1'b0;

    csr_enc_core dut (
        .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .nz_val(nz_val), .nz_col(nz_col), .nz_valid(nz_valid), .nz_ready(nz_ready),
        .rp_data(rp_data), .rp_valid(rp_valid), .rp_ready(rp_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        toggleBit = ~toggleBit;
    end

    // Transfers are recorded at the negedge before the posedge that completes them.
    always @(negedge clk) begin
        if (!reset) begin
            if (nz_valid && nz_ready) begin
                nzValQ.push_back(nz_val);
                nzColQ.push_back(nz_col);
            end
            if (rp_valid && rp_ready) rpQ.push_back(rp_data);
            if (done) begin
                doneCount++;
                busyAtDone = busy;
                busyBeforeDone = lastBusy;
            end
            if (cfg_err) errCount++;
            if (nz_valid && !nz_ready && in_ready) violations++;
            if (nz_valid && !nz_ready && in_valid && !in_ready) blocked++;
            lastBusy = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] val14(input int v);
        logic [13:0] t;
        t = v[13:0];
        return {18'b0, t};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkNz(input string tag, input int idx, input int v, input int c);
        if (idx < nzValQ.size()) begin
            checkOutput({tag, "_val"}, 32'(nzValQ[idx]), val14(v));
            checkOutput({tag, "_col"}, 32'(nzColQ[idx]), 32'(c));
        end else begin
            checkOutput({tag, "_missing"}, 32'(nzValQ.size()), 32'(idx + 1));
        end
    endtask

    task automatic checkRp(input string tag, input int idx, input int v);
        if (idx < rpQ.size()) checkOutput(tag, 32'(rpQ[idx]), 32'(v));
        else checkOutput({tag, "_missing"}, 32'(rpQ.size()), 32'(idx + 1));
    endtask

    task automatic clearLog();
        nzValQ.delete();
        nzColQ.delete();
        rpQ.delete();
        doneCount = 0; errCount = 0; violations = 0; blocked = 0;
        busyAtDone = 1'b1; busyBeforeDone = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic startMatrix(input int r, input int c);
        cfg_rows = 14'(r);
        cfg_cols = 14'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one element and returns once the DUT has taken it.
    task automatic applyStimulus(input int d);
        int n;
        n = 0;
        in_data = 14'(d);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_rows = '0; cfg_cols = '0; rp_ready = 1'b1;
        settle(3);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_valids", {29'b0, nz_valid, rp_valid, in_ready}, 0);
        checkOutput("rst_pulses", {30'b0, done, cfg_err}, 0);
        checkOutput("rst_data", 32'(nz_val) | 32'(nz_col) | 32'(rp_data), 0);
        reset = 1'b0;
        settle(1);

        // 2x3 [5,0,-3 / 0,0,7]
        clearLog();
        startMatrix(2, 3);
        applyStimulus(5); applyStimulus(0); applyStimulus(-3);
        applyStimulus(0); applyStimulus(0); applyStimulus(7);
        settle(20);
        checkOutput("t1_nz_count", 32'(nzValQ.size()), 3);
        checkNz("t1_nz0", 0, 5, 0);
        checkNz("t1_nz1", 1, -3, 2);
        checkNz("t1_nz2", 2, 7, 2);
        checkOutput("t1_rp_count", 32'(rpQ.size()), 3);
        checkRp("t1_rp0", 0, 0);
        checkRp("t1_rp1", 1, 2);
        checkRp("t1_rp2", 2, 3);
        checkOutput("t1_done_count", 32'(doneCount), 1);
        checkOutput("t1_busy_at_done", 32'(busyAtDone), 0);
        checkOutput("t1_busy_before_done", 32'(busyBeforeDone), 1);

        // 3x2 all zero, with the first row pointer held off for a while
        clearLog();
        rp_ready = 1'b0;
        startMatrix(3, 2);
        settle(3);
        checkOutput("t2_rp0_held_valid", 32'(rp_valid), 1);
        checkOutput("t2_rp0_held_data", 32'(rp_data), 0);
        checkOutput("t2_rp0_in_ready", 32'(in_ready), 0);
        checkOutput("t2_rp0_busy", 32'(busy), 1);
        rp_ready = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(0);
        settle(20);
        checkOutput("t2_nz_count", 32'(nzValQ.size()), 0);
        checkOutput("t2_rp_count", 32'(rpQ.size()), 4);
        for (int i = 0; i < 4; i++) checkRp($sformatf("t2_rp%0d", i), i, 0);
        checkOutput("t2_done_count", 32'(doneCount), 1);

        // 1x4 [1,2,3,4] with nz_ready toggling every cycle
        clearLog();
        toggleMode = 1'b1;
        startMatrix(1, 4);
        for (int i = 1; i <= 4; i++) applyStimulus(i);
        settle(20);
        toggleMode = 1'b0;
        checkOutput("t3_nz_count", 32'(nzValQ.size()), 4);
        for (int i = 0; i < 4; i++) checkNz($sformatf("t3_nz%0d", i), i, i + 1, i);
        checkRp("t3_rp0", 0, 0);
        checkRp("t3_rp1", 1, 4);
        checkOutput("t3_rp_count", 32'(rpQ.size()), 2);
        checkOutput("t3_ready_violations", 32'(violations), 0);
        checkOutput("t3_blocked_seen", 32'(blocked > 0), 1);

        // zero row count rejected
        clearLog();
        cfg_rows = 14'd0;
        cfg_cols = 14'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("t4_cfg_err_pulse", 32'(cfg_err), 1);
        checkOutput("t4_busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("t4_cfg_err_clear", 32'(cfg_err), 0);
        settle(5);
        checkOutput("t4_no_output", 32'(rpQ.size() + nzValQ.size()), 0);
        checkOutput("t4_err_count", 32'(errCount), 1);

        // reset in SCAN after two accepted elements
        clearLog();
        startMatrix(2, 3);
        applyStimulus(3);
        applyStimulus(6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_valids", {30'b0, nz_valid, rp_valid}, 0);
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_in_ready", 32'(in_ready), 0);
        checkOutput("t5_nz_val", 32'(nz_val), 0);
        clearLog();
        startMatrix(1, 1);
        applyStimulus(9);
        settle(20);
        checkOutput("t5_nz_count", 32'(nzValQ.size()), 1);
        checkNz("t5_nz0", 0, 9, 0);
        checkOutput("t5_rp_count", 32'(rpQ.size()), 2);
        checkRp("t5_rp0", 0, 0);
        checkRp("t5_rp1", 1, 1);
        checkOutput("t5_done_count", 32'(doneCount), 1);

        // start pulse during SCAN is ignored
        clearLog();
        startMatrix(2, 2);
        applyStimulus(1);
        startMatrix(1, 1);
        applyStimulus(0);
        applyStimulus(0);
        applyStimulus(2);
        settle(20);
        checkOutput("t6_nz_count", 32'(nzValQ.size()), 2);
        checkNz("t6_nz0", 0, 1, 0);
        checkNz("t6_nz1", 1, 2, 1);
        checkOutput("t6_rp_count", 32'(rpQ.size()), 3);
        checkRp("t6_rp0", 0, 0);
        checkRp("t6_rp1", 1, 1);
        checkRp("t6_rp2", 2, 2);
        checkOutput("t6_done_count", 32'(doneCount), 1);
        checkOutput("t6_busy_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
